// File: rtl/ne_window_monitor.sv
// ne_window_monitor: groups the 1-bit ne comparator stream into fixed windows
// of WINDOW samples and emits one report per window (mismatch count, index of
// the first mismatch, any-mismatch flag, saturation flag) through a one-entry
// valid/ready output register. Input is stalled while a finished window
// cannot be handed to the output register.
module ne_window_monitor #(
    parameter int WINDOW = 1000,
    parameter int CNT_W  = 16,
    parameter int IDX_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync_clr,
    input  logic             in_valid,
    input  logic             in_ne,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic [IDX_W-1:0] out_first_idx,
    output logic             out_any,
    output logic             out_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [IDX_W-1:0] NO_IDX   = {IDX_W{1'b1}};
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW - 1);

    typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   acc_count_q, acc_count_d;
    logic [IDX_W-1:0]   acc_first_q, acc_first_d;
    logic               acc_any_q, acc_any_d;
    logic               acc_sat_q, acc_sat_d;
    logic               out_valid_q, out_valid_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic [IDX_W-1:0]   out_first_q, out_first_d;
    logic               out_any_q, out_any_d;
    logic               out_sat_q, out_sat_d;

    logic               beat;
    logic               out_free;
    logic [CNT_W-1:0]   upd_count;
    logic [IDX_W-1:0]   upd_first;
    logic               upd_any;
    logic               upd_sat;

    assign in_ready      = (state_q == COLLECT);
    assign beat          = in_valid && in_ready;
    assign out_free      = !out_valid_q || out_ready;

    assign out_valid     = out_valid_q;
    assign out_count     = out_count_q;
    assign out_first_idx = out_first_q;
    assign out_any       = out_any_q;
    assign out_sat       = out_sat_q;

    // Accumulator values as they would be after folding in the current sample;
    // used both for mid-window updates and for the window-end report.
    always_comb begin
        upd_count = acc_count_q;
        upd_first = acc_first_q;
        upd_any   = acc_any_q;
        upd_sat   = acc_sat_q;
        if (in_ne) begin
            // sat marks a mismatch that could not be counted
            if (acc_count_q == CNT_MAX) upd_sat = 1'b1;
            else                        upd_count = acc_count_q + 1'b1;
            if (!acc_any_q) begin
                upd_first = idx_q;
                upd_any   = 1'b1;
            end
        end
    end

    // Next-state: window sequencing, HOLD handoff, abort and output register.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_count_d = acc_count_q;
        acc_first_d = acc_first_q;
        acc_any_d   = acc_any_q;
        acc_sat_d   = acc_sat_q;
        // a handshake empties the register unless a report loads below
        out_valid_d = out_valid_q && !out_ready;
        out_count_d = out_count_q;
        out_first_d = out_first_q;
        out_any_d   = out_any_q;
        out_sat_d   = out_sat_q;

        if (sync_clr) begin
            // abort: drop current (or held) window, output register untouched
            state_d     = COLLECT;
            idx_d       = '0;
            acc_count_d = '0;
            acc_first_d = NO_IDX;
            acc_any_d   = 1'b0;
            acc_sat_d   = 1'b0;
        end else if (state_q == HOLD) begin
            // out_valid is always set in HOLD, so out_ready means handshake
            if (out_ready) begin
                out_valid_d = 1'b1;
                out_count_d = acc_count_q;
                out_first_d = acc_first_q;
                out_any_d   = acc_any_q;
                out_sat_d   = acc_sat_q;
                state_d     = COLLECT;
                idx_d       = '0;
                acc_count_d = '0;
                acc_first_d = NO_IDX;
                acc_any_d   = 1'b0;
                acc_sat_d   = 1'b0;
            end
        end else if (beat) begin
            if (idx_q == LAST_IDX) begin
                if (out_free) begin
                    // back-to-back: report loads and the next window starts now
                    out_valid_d = 1'b1;
                    out_count_d = upd_count;
                    out_first_d = upd_first;
                    out_any_d   = upd_any;
                    out_sat_d   = upd_sat;
                    idx_d       = '0;
                    acc_count_d = '0;
                    acc_first_d = NO_IDX;
                    acc_any_d   = 1'b0;
                    acc_sat_d   = 1'b0;
                end else begin
                    // freeze the final window values until the register drains
                    state_d     = HOLD;
                    acc_count_d = upd_count;
                    acc_first_d = upd_first;
                    acc_any_d   = upd_any;
                    acc_sat_d   = upd_sat;
                end
            end else begin
                idx_d       = idx_q + 1'b1;
                acc_count_d = upd_count;
                acc_first_d = upd_first;
                acc_any_d   = upd_any;
                acc_sat_d   = upd_sat;
            end
        end
    end

    // State and output registers; reset discards any window and pending report.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            idx_q       <= '0;
            acc_count_q <= '0;
            acc_first_q <= NO_IDX;
            acc_any_q   <= 1'b0;
            acc_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
            out_first_q <= NO_IDX;
            out_any_q   <= 1'b0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_count_q <= acc_count_d;
            acc_first_q <= acc_first_d;
            acc_any_q   <= acc_any_d;
            acc_sat_q   <= acc_sat_d;
            out_valid_q <= out_valid_d;
            out_count_q <= out_count_d;
            out_first_q <= out_first_d;
            out_any_q   <= out_any_d;
            out_sat_q   <= out_sat_d;
        end
    end

endmodule

// File: tb/tb_ne_window_monitor.sv
// Directed bench for ne_window_monitor with WINDOW=8, CNT_W=3, IDX_W=4.
module tb_ne_window_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sync_clr = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ne = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [2:0] out_count;
    logic [3:0] out_first_idx;
    logic       out_any;
    logic       out_sat;

    int checks = 0;
    int errors = 0;

    ne_window_monitor #(.WINDOW(8), .CNT_W(3), .IDX_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sync_clr      (sync_clr),
        .in_valid      (in_valid),
        .in_ne         (in_ne),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_count     (out_count),
        .out_first_idx (out_first_idx),
        .out_any       (out_any),
        .out_sat       (out_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one accepted beat; inputs change 1 time unit after the rising edge
    task automatic beat(input logic ne, input string tag);
        in_valid = 1'b1;
        in_ne    = ne;
        chk(tag, in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_ne    = 1'b0;
    endtask

    // full window, bit i of pat is the sample at index i
    task automatic window(input logic [7:0] pat, input string tag);
        for (int i = 0; i < 8; i++) beat(pat[i], tag);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk_rep(input string tag, input logic [2:0] c, input logic [3:0] f,
                           input logic a, input logic s);
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_count"}, out_count, c);
        chk({tag, "_first"}, out_first_idx, f);
        chk({tag, "_any"},   out_any, a);
        chk({tag, "_sat"},   out_sat, s);
    endtask

    initial begin
        #12;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_first", out_first_idx, 4'hF);
        chk("rst_count", out_count, 3'd0);
        chk("rst_ready", in_ready, 1'b1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: clean window
        window(8'h00, "t1_rdy");
        chk_rep("t1", 3'd0, 4'hF, 1'b0, 1'b0);
        idle(1);
        chk("t1_one_cycle", out_valid, 1'b0);

        // 2: mismatches at 2 and 5, then 3: all mismatches with no gap
        window(8'h24, "t2_rdy");
        chk_rep("t2", 3'd2, 4'd2, 1'b1, 1'b0);
        window(8'hFF, "t3_rdy");
        chk_rep("t3", 3'd7, 4'd0, 1'b1, 1'b1);
        idle(1);
        chk("t3_drop", out_valid, 1'b0);

        // 4: back-pressure, A = mismatch at 4, B = mismatches at 0 and 7
        out_ready = 1'b0;
        window(8'h10, "t4a_rdy");
        chk_rep("t4a", 3'd1, 4'd4, 1'b1, 1'b0);
        window(8'h81, "t4b_rdy");
        chk("t4_hold_rdy", in_ready, 1'b0);
        idle(2);
        chk("t4_hold_rdy2", in_ready, 1'b0);
        chk_rep("t4a_held", 3'd1, 4'd4, 1'b1, 1'b0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk_rep("t4b", 3'd2, 4'd0, 1'b1, 1'b0);
        chk("t4_rdy_back", in_ready, 1'b1);
        out_ready = 1'b1;
        idle(1);
        chk("t4_drop", out_valid, 1'b0);

        // 5: partial window aborted by sync_clr with a beat on the same cycle
        window(8'h00, "t5_pre");
        idle(1);
        for (int i = 0; i < 4; i++) beat(i == 1, "t5_part");
        sync_clr = 1'b1; in_valid = 1'b1; in_ne = 1'b1;
        @(posedge clk); #1;
        sync_clr = 1'b0; in_valid = 1'b0; in_ne = 1'b0;
        chk("t5_no_rep", out_valid, 1'b0);
        for (int i = 0; i < 7; i++) beat(1'b0, "t5_rdy");
        chk("t5_early", out_valid, 1'b0);
        beat(1'b0, "t5_rdy");
        chk_rep("t5", 3'd0, 4'hF, 1'b0, 1'b0);
        idle(1);

        // 6: async reset mid-window while a report is pending
        out_ready = 1'b0;
        window(8'h00, "t6_pre");
        chk("t6_pend", out_valid, 1'b1);
        for (int i = 0; i < 3; i++) beat(1'b1, "t6_part");
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_valid", out_valid, 1'b0);
        chk("t6_async_first", out_first_idx, 4'hF);
        @(negedge clk); rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        window(8'h08, "t6_rdy");
        chk_rep("t6", 3'd1, 4'd3, 1'b1, 1'b0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
